// File: rtl/axi4_burst_mem_slave.sv
// ----------------------------------------------------------------------------
// axi4_burst_mem_slave
//   AXI4 memory-mapped slave backed by a word-wide memory.
//   Supports FIXED/INCR/WRAP bursts, WSTRB byte enables and per-beat SLVERR.
//   The write and read engines are independent and may both accept an
//   address in the same cycle.
//
// Ports
//   ACLK, ARESET                 clock, synchronous active-high reset
//   AW*  (ADDR/LEN/BURST/VALID/READY)  write address channel
//   W*   (DATA/STRB/LAST/VALID/READY)  write data channel
//   B*   (RESP/VALID/READY)            write response channel
//   AR*  (ADDR/LEN/BURST/VALID/READY)  read address channel
//   R*   (DATA/RESP/LAST/VALID/READY)  read data channel
// ----------------------------------------------------------------------------
module axi4_burst_mem_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(BYTES);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W    = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {BURST_FIXED, BURST_INCR, BURST_WRAP, BURST_RSVD} burst_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Reserved burst type, or a WRAP whose length is not 2/4/8/16 beats.
    function automatic logic burst_bad(input logic [1:0] burst, input logic [7:0] len);
        return (burst == BURST_RSVD) ||
               (burst == BURST_WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    endfunction

    // WRAP keeps the high bits of the (len+1)*BYTES window and wraps the low bits.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [1:0] burst,
                                                        input logic [7:0] len);
        logic [ADDR_WIDTH-1:0] mask;
        mask = (ADDR_WIDTH'(len) << OFFS) | ALIGN_MASK;
        case (burst)
            BURST_INCR: next_addr = addr + ADDR_WIDTH'(BYTES);
            BURST_WRAP: next_addr = (addr & ~mask) | ((addr + ADDR_WIDTH'(BYTES)) & mask);
            default:    next_addr = addr;
        endcase
    endfunction

    // ---------------------------------------------------------------- write
    w_state_e              w_state;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len, w_cnt;
    logic [1:0]            w_burst;
    logic                  w_bad, w_err;
    logic [ADDR_WIDTH:0]   w_word;
    logic                  w_fire, w_in, w_last_beat, beat_err;

    assign w_word      = {1'b0, w_addr} >> OFFS;
    assign w_in        = w_word < DEPTH_W;
    assign w_fire      = (w_state == W_DATA) && WVALID && WREADY;
    assign w_last_beat = (w_cnt == w_len);
    assign beat_err    = !w_in || (WLAST != w_last_beat);

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state <= W_IDLE;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BRESP   <= RESP_OKAY;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_burst <= '0;
            w_bad   <= 1'b0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    AWREADY <= 1'b1;
                    if (AWVALID && AWREADY) begin
                        AWREADY <= 1'b0;
                        WREADY  <= 1'b1;
                        w_addr  <= AWADDR & ~ALIGN_MASK;
                        w_len   <= AWLEN;
                        w_burst <= AWBURST;
                        w_cnt   <= '0;
                        w_bad   <= burst_bad(AWBURST, AWLEN);
                        w_err   <= 1'b0;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        if (w_last_beat) begin
                            WREADY  <= 1'b0;
                            BVALID  <= 1'b1;
                            BRESP   <= (w_bad || w_err || beat_err) ? RESP_SLVERR : RESP_OKAY;
                            w_state <= W_RESP;
                        end else begin
                            w_cnt  <= w_cnt + 8'd1;
                            w_addr <= next_addr(w_addr, w_burst, w_len);
                            w_err  <= w_err || beat_err;
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        BRESP   <= RESP_OKAY;
                        AWREADY <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // NOTE: the memory array has no reset; its contents survive ARESET and
    // leaving it out lets the array map onto RAM macros.
    always_ff @(posedge ACLK) begin
        if (!ARESET && w_fire && w_in && !w_bad) begin
            for (int b = 0; b < BYTES; b++) begin
                if (WSTRB[b]) mem[w_word[IDX_W-1:0]][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
    end

    // ----------------------------------------------------------------- read
    r_state_e              r_state;
    logic [ADDR_WIDTH-1:0] r_addr, f_addr;
    logic [7:0]            r_len, r_cnt;
    logic [1:0]            r_burst;
    logic                  r_bad, f_bad, f_ok;
    logic [ADDR_WIDTH:0]   f_word;
    logic [DATA_WIDTH-1:0] f_data;

    // Address and data of the beat to be registered at the next edge: the
    // first beat while idle, otherwise the beat following the one on R.
    // NOTE: every always_comb output gets a value on every path to avoid latches.
    always_comb begin
        if (r_state == R_IDLE) begin
            f_addr = ARADDR & ~ALIGN_MASK;
            f_bad  = burst_bad(ARBURST, ARLEN);
        end else begin
            f_addr = next_addr(r_addr, r_burst, r_len);
            f_bad  = r_bad;
        end
        f_word = {1'b0, f_addr} >> OFFS;
        f_ok   = !f_bad && (f_word < DEPTH_W);
        f_data = f_ok ? mem[f_word[IDX_W-1:0]] : '0;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= R_IDLE;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RDATA   <= '0;
            RRESP   <= RESP_OKAY;
            RLAST   <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_burst <= '0;
            r_bad   <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    ARREADY <= 1'b1;
                    if (ARVALID && ARREADY) begin
                        ARREADY <= 1'b0;
                        r_addr  <= f_addr;
                        r_len   <= ARLEN;
                        r_burst <= ARBURST;
                        r_bad   <= f_bad;
                        r_cnt   <= '0;
                        RVALID  <= 1'b1;
                        RDATA   <= f_data;
                        RRESP   <= f_ok ? RESP_OKAY : RESP_SLVERR;
                        RLAST   <= (ARLEN == 8'd0);
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        if (RLAST) begin
                            RVALID  <= 1'b0;
                            RDATA   <= '0;
                            RRESP   <= RESP_OKAY;
                            RLAST   <= 1'b0;
                            ARREADY <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_addr <= f_addr;
                            r_cnt  <= r_cnt + 8'd1;
                            RDATA  <= f_data;
                            RRESP  <= f_ok ? RESP_OKAY : RESP_SLVERR;
                            RLAST  <= (r_cnt + 8'd1 == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// ----------------------------------------------------------------------------
// tb_axi4_burst_mem_slave
//   Directed bench for axi4_burst_mem_slave (32-bit data, 16-bit address,
//   1024 words). Stimulus tasks push expected B and R responses into queues;
//   independent monitors pop and compare them on every B/R handshake.
// ----------------------------------------------------------------------------
module tb_axi4_burst_mem_slave;

    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;
    localparam logic [1:0] OKAY  = 2'b00, SLVERR = 2'b10;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [15:0] AWADDR, ARADDR;
    logic [7:0]  AWLEN, ARLEN;
    logic [1:0]  AWBURST, ARBURST;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

    axi4_burst_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_DEPTH(1024)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    logic [1:0] bq[$];
    rbeat_t     rq[$];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
        finish_sim();
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Monitors: inputs change only just after posedge, so a handshake seen at
    // negedge is the one that completes at the following posedge.
    always @(negedge ACLK) begin
        if (!ARESET && BVALID && BREADY) begin
            if (bq.size() == 0) check("unexpected_b", 1'b1, 1'b0);
            else check("bresp", BRESP, bq.pop_front());
        end
    end

    always @(negedge ACLK) begin : r_mon
        rbeat_t e;
        if (!ARESET && RVALID && RREADY) begin
            if (rq.size() == 0) check("unexpected_r", 1'b1, 1'b0);
            else begin
                e = rq.pop_front();
                check("rdata", RDATA, e.data);
                check("rresp", RRESP, e.resp);
                check("rlast", RLAST, e.last);
            end
        end
    end

    task automatic exp_beat(input logic [31:0] data, input logic [1:0] resp, input logic last);
        rbeat_t e;
        e.data = data;
        e.resp = resp;
        e.last = last;
        rq.push_back(e);
    endtask

    task automatic wait_empty();
        for (int n = 0; bq.size() != 0 || rq.size() != 0; n++) begin
            if (n == 300) fail_timeout("response_drain");
            tick();
        end
        tick();
    endtask

    task automatic aw_phase(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst);
        AWADDR = addr; AWLEN = len; AWBURST = burst; AWVALID = 1'b1;
        for (int n = 0; !AWREADY; n++) begin
            if (n == 200) fail_timeout("awready");
            tick();
        end
        tick();
        AWVALID = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
        for (int n = 0; !WREADY; n++) begin
            if (n == 200) fail_timeout("wready");
            tick();
        end
        tick();
        WVALID = 1'b0;
        WLAST  = 1'b0;
    endtask

    // Beat i carries d0+i; bad_last raises WLAST on beat 0 instead of the last beat.
    task automatic write_burst(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst,
                               input logic [31:0] d0, input logic [3:0] strb, input logic [1:0] exp_resp,
                               input bit bad_last, input bit wait_b);
        bq.push_back(exp_resp);
        aw_phase(addr, len, burst);
        for (int i = 0; i <= int'(len); i++)
            w_beat(d0 + 32'(i), strb, bad_last ? (i == 0) : (i == int'(len)));
        if (wait_b) wait_empty();
    endtask

    task automatic read_burst(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst);
        ARADDR = addr; ARLEN = len; ARBURST = burst; ARVALID = 1'b1;
        for (int n = 0; !ARREADY; n++) begin
            if (n == 200) fail_timeout("arready");
            tick();
        end
        tick();
        ARVALID = 1'b0;
        wait_empty();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_awready"}, AWREADY, 1'b0);
        check({tag, "_wready"},  WREADY,  1'b0);
        check({tag, "_bvalid"},  BVALID,  1'b0);
        check({tag, "_bresp"},   BRESP,   2'b00);
        check({tag, "_arready"}, ARREADY, 1'b0);
        check({tag, "_rvalid"},  RVALID,  1'b0);
        check({tag, "_rdata"},   RDATA,   32'h0);
        check({tag, "_rresp"},   RRESP,   2'b00);
        check({tag, "_rlast"},   RLAST,   1'b0);
    endtask

    initial begin
        #200000;
        fail_timeout("watchdog");
    end

    initial begin
        ARESET = 1'b1;
        AWADDR = '0; AWLEN = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
        ARADDR = '0; ARLEN = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b1;

        // Reset state and ready rising one cycle after reset release.
        repeat (3) tick();
        check_outputs_zero("reset");
        ARESET = 1'b0;
        check("awready_before_release_edge", AWREADY, 1'b0);
        tick();
        check("awready_after_reset", AWREADY, 1'b1);
        check("arready_after_reset", ARREADY, 1'b1);

        // INCR write and read-back.
        write_burst(16'h0010, 8'd3, INCR, 32'hA0, 4'hF, OKAY, 1'b0, 1'b1);
        exp_beat(32'hA0, OKAY, 1'b0); exp_beat(32'hA1, OKAY, 1'b0);
        exp_beat(32'hA2, OKAY, 1'b0); exp_beat(32'hA3, OKAY, 1'b1);
        read_burst(16'h0010, 8'd3, INCR);

        // WRAP len3 at 0x38: words 0x38,0x3C,0x30,0x34 get B0..B3.
        write_burst(16'h0038, 8'd3, WRAP, 32'hB0, 4'hF, OKAY, 1'b0, 1'b1);
        exp_beat(32'hB2, OKAY, 1'b0); exp_beat(32'hB3, OKAY, 1'b0);
        exp_beat(32'hB0, OKAY, 1'b0); exp_beat(32'hB1, OKAY, 1'b1);
        read_burst(16'h0030, 8'd3, INCR);
        exp_beat(32'hB0, OKAY, 1'b0); exp_beat(32'hB1, OKAY, 1'b0);
        exp_beat(32'hB2, OKAY, 1'b0); exp_beat(32'hB3, OKAY, 1'b1);
        read_burst(16'h0038, 8'd3, WRAP);

        // WRAP len2 is illegal: SLVERR and memory untouched.
        write_burst(16'h0030, 8'd2, WRAP, 32'hC0, 4'hF, SLVERR, 1'b0, 1'b1);
        exp_beat(32'hB2, OKAY, 1'b0); exp_beat(32'hB3, OKAY, 1'b0);
        exp_beat(32'hB0, OKAY, 1'b0); exp_beat(32'hB1, OKAY, 1'b1);
        read_burst(16'h0030, 8'd3, INCR);

        // Byte strobes: 0101 over zero.
        write_burst(16'h0040, 8'd0, INCR, 32'h0, 4'hF, OKAY, 1'b0, 1'b1);
        write_burst(16'h0040, 8'd0, INCR, 32'hFFFF_FFFF, 4'b0101, OKAY, 1'b0, 1'b1);
        exp_beat(32'h00FF_00FF, OKAY, 1'b1);
        read_burst(16'h0040, 8'd0, INCR);

        // FIXED burst: every beat hits the same word, last one stays.
        write_burst(16'h0050, 8'd3, FIXED, 32'hD0, 4'hF, OKAY, 1'b0, 1'b1);
        exp_beat(32'hD3, OKAY, 1'b1);
        read_burst(16'h0050, 8'd0, INCR);

        // Top word in range, next word past the end.
        write_burst(16'h0FFC, 8'd0, INCR, 32'hE5, 4'hF, OKAY, 1'b0, 1'b1);
        exp_beat(32'hE5, OKAY, 1'b0); exp_beat(32'h0, SLVERR, 1'b1);
        read_burst(16'h0FFC, 8'd1, INCR);
        write_burst(16'h1000, 8'd0, INCR, 32'hE6, 4'hF, SLVERR, 1'b0, 1'b1);

        // Reserved burst type on both engines, and a misplaced WLAST.
        write_burst(16'h0010, 8'd1, RSVD, 32'h55, 4'hF, SLVERR, 1'b0, 1'b1);
        exp_beat(32'h0, SLVERR, 1'b0); exp_beat(32'h0, SLVERR, 1'b1);
        read_burst(16'h0010, 8'd1, RSVD);
        write_burst(16'h0080, 8'd1, INCR, 32'h66, 4'hF, SLVERR, 1'b1, 1'b1);

        // BREADY held low: response must hold steady.
        BREADY = 1'b0;
        write_burst(16'h0070, 8'd0, INCR, 32'h77, 4'hF, OKAY, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("bvalid_held", BVALID, 1'b1);
            check("bresp_held", BRESP, OKAY);
            tick();
        end
        BREADY = 1'b1;
        wait_empty();
        check("awready_after_b", AWREADY, 1'b1);

        // Reset in the middle of a write burst (beat 2 of 4).
        aw_phase(16'h0060, 8'd3, INCR);
        w_beat(32'hF0, 4'hF, 1'b0);
        w_beat(32'hF1, 4'hF, 1'b0);
        WDATA = 32'hF2; WSTRB = 4'hF; WVALID = 1'b1;
        ARESET = 1'b1;
        tick();
        check_outputs_zero("midreset");
        ARESET = 1'b0;
        WVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("no_b_after_reset", BVALID, 1'b0);
            tick();
        end
        write_burst(16'h0060, 8'd3, INCR, 32'h90, 4'hF, OKAY, 1'b0, 1'b1);
        exp_beat(32'h90, OKAY, 1'b0); exp_beat(32'h91, OKAY, 1'b0);
        exp_beat(32'h92, OKAY, 1'b0); exp_beat(32'h93, OKAY, 1'b1);
        read_burst(16'h0060, 8'd3, INCR);

        repeat (3) tick();
        check("b_queue_drained", 32'(bq.size()), 32'd0);
        check("r_queue_drained", 32'(rq.size()), 32'd0);
        finish_sim();
    end

endmodule
